modaddsub_pipe: RTL

Multi-lane, pipelined modular add/subtract/negate/accumulate unit for the NTT/INTT datapath. It is the sequential, parametrised successor to the single-lane combinational add-then-reduce cell. Each accepted beat carries LANES coefficients and one operation code. It sits between the coefficient buffers and the butterfly/post-processing stages, behind a valid/ready handshake with full backpressure.

---
 rtl/modaddsub_pipe.sv | 130 +++++++++++++
 1 files changed

// File: rtl/modaddsub_pipe.sv
// Multi-lane two-stage modular add/sub/negate/accumulate unit with valid/ready flow control.
// S1 forms raw per-lane results (plus in-cycle ACC reduction); S2 finishes the ADD reduction.
module modaddsub_pipe #(
    parameter int COE_WIDTH = 39,
    parameter int Q_TYPE    = 0,
    parameter int LANES     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [1:0]                   i_op,
    input  logic                         i_last,
    input  logic [LANES*COE_WIDTH-1:0]   i_a,
    input  logic [LANES*COE_WIDTH-1:0]   i_b,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [LANES*COE_WIDTH-1:0]   o_res,
    output logic                         o_last
);

    localparam int CW = COE_WIDTH;

    // Modulus table shared with the rest of the NTT/INTT datapath.
    localparam logic [63:0] Q0 = 64'h0000_007F_FFF0_0001;
    localparam logic [63:0] Q1 = 64'h0000_007F_FFE8_0001;
    localparam logic [63:0] Q2 = 64'h0000_007F_FFD4_0001;
    localparam logic [63:0] Q_SEL = (Q_TYPE == 2) ? Q2 : ((Q_TYPE == 1) ? Q1 : Q0);
    localparam logic [CW:0] Q = Q_SEL[CW:0];

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;

    logic en;
    logic accept;
    logic acc_hold;
    logic s1_valid_reg;
    logic s1_add_reg;
    logic s1_last_reg;
    logic o_valid_reg;
    logic o_last_reg;

    assign en       = !o_valid_reg || i_ready;
    assign o_ready  = en;
    assign accept   = i_valid && en;
    // A non-final ACC beat only updates the accumulators and leaves a bubble.
    assign acc_hold = (i_op == OP_ACC) && !i_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_add_reg   <= 1'b0;
            s1_last_reg  <= 1'b0;
            o_valid_reg  <= 1'b0;
            o_last_reg   <= 1'b0;
        end else if (en) begin
            s1_valid_reg <= accept && !acc_hold;
            s1_add_reg   <= (i_op == OP_ADD);
            s1_last_reg  <= i_last;
            o_valid_reg  <= s1_valid_reg;
            if (s1_valid_reg) begin
                o_last_reg <= s1_last_reg;
            end
        end
    end

    assign o_valid = o_valid_reg;
    assign o_last  = o_last_reg;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [CW-1:0] acc_reg;
            logic [CW-1:0] acc_next;
            logic [CW:0]   s1_res_reg;
            logic [CW:0]   s1_next;
            logic [CW-1:0] o_res_reg;
            logic [CW-1:0] s2_next;
            logic [CW:0]   a_x;
            logic [CW:0]   b_x;
            logic [CW:0]   acc_sum;

            assign a_x      = {1'b0, i_a[gi*CW +: CW]};
            assign b_x      = {1'b0, i_b[gi*CW +: CW]};
            assign acc_sum  = {1'b0, acc_reg} + a_x;
            assign acc_next = CW'((acc_sum >= Q) ? (acc_sum - Q) : acc_sum);

            always_comb begin
                s1_next = '0;
                case (i_op)
                    OP_ADD:  s1_next = a_x + b_x;
                    // a + Q - b stays below Q when a < b, so the wrap is exact.
                    OP_SUB:  s1_next = (a_x < b_x) ? (a_x + Q - b_x) : (a_x - b_x);
                    OP_ACC:  s1_next = {1'b0, acc_next};
                    default: s1_next = (a_x == '0) ? '0 : (Q - a_x);
                endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_reg <= '0;
                end else if (accept && (i_op == OP_ACC)) begin
                    acc_reg <= i_last ? '0 : acc_next;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_res_reg <= '0;
                end else if (en) begin
                    s1_res_reg <= s1_next;
                end
            end

            assign s2_next = CW'((s1_add_reg && (s1_res_reg >= Q)) ? (s1_res_reg - Q) : s1_res_reg);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    o_res_reg <= '0;
                end else if (en && s1_valid_reg) begin
                    o_res_reg <= s2_next;
                end
            end

            assign o_res[gi*CW +: CW] = o_res_reg;
        end
    endgenerate

endmodule
